type_decode_stage: RTL and testbench
====================================

TYPE_DECODE_STAGE -- requirements
Module: type_decode_stage

Interface
REQ-001 SHALL provide clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide rst_ni, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL provide flush_i, input, 1, synchronous discard of all buffered instructions.
REQ-004 SHALL provide in_valid_i, input, 1, upstream fetch holds a valid instruction.
REQ-005 SHALL provide in_ready_o, output, 1, stage accepts an instruction this cycle.
REQ-006 SHALL provide instr_i, input, 32, instruction word; pc_i, input, 32, its address.
REQ-007 SHALL provide out_valid_o, output, 1, decoded entry presented downstream.
REQ-008 SHALL provide out_ready_i, input, 1, downstream consumes the presented entry.
REQ-009 SHALL provide instr_o, 32, and pc_o, 32, outputs, the presented instruction and PC.
REQ-010 SHALL provide rtype_o, itype_o, store_o, load_o, branch_o, jal_o, jalr_o, lui_o, outputs, 1 each, one-hot type flags feeding aluop.
REQ-011 SHALL provide illegal_o, output, 1, presented instruction has an unsupported encoding; illegal_cnt_o, output, 8, saturating illegal count.

Function
REQ-012 SHALL implement a 2-entry skid buffer: output register (OUT) plus skid register (SKID).
REQ-013 SHALL drive in_ready_o as registered "SKID empty"; no combinational path from out_ready_i to in_ready_o.
REQ-014 SHALL transfer on in_valid_i && in_ready_o (accept) and out_valid_o && out_ready_i (consume).
REQ-015 SHALL, on accept with OUT empty or consumed same cycle, load OUT; otherwise load SKID.
REQ-016 SHALL, on consume with SKID full, move SKID to OUT and mark SKID empty next cycle.
REQ-017 SHALL give 1-cycle latency: instruction accepted in cycle N presented in N+1 when OUT free.
REQ-018 SHALL decode type from instr[6:0] at accept and store flags with the entry: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui.
REQ-019 SHALL assert at most one type flag; all flags 0 when out_valid_o is 0.
REQ-020 SHALL hold OUT contents and all outputs stable while out_valid_o && !out_ready_i.
REQ-021 SHALL, on flush_i, clear both entries' valid next cycle, ignore same-cycle accept, and leave illegal_cnt_o unchanged.
REQ-022 SHALL give flush_i priority over accept and consume in the same cycle.

Reset
REQ-023 SHALL, with rst_ni low at a clock edge, clear OUT and SKID valid, all flags, illegal_o and illegal_cnt_o to 0, and drive in_ready_o to 1.
REQ-024 SHALL clear instr_o and pc_o to 0 at reset.
REQ-025 SHALL discard any in-flight entry when reset is asserted mid-operation; no partial transfer survives.

Configuration
REQ-026 SHALL honour macro TYPE_DECODE_ILLEGAL_EN: defined -> illegal_o set for any opcode not in REQ-018 or instr[1:0] != 2'b11; illegal_cnt_o increments per illegal entry consumed and saturates at 255.
REQ-027 SHALL, without TYPE_DECODE_ILLEGAL_EN, tie illegal_o and illegal_cnt_o to 0; unknown opcodes pass with all flags 0.

Structure
REQ-028 SHALL place opcode constants and a packed decoded-entry typedef (instr, pc, flags, illegal) in shared package core_pkg.
REQ-029 SHALL use one combinational sub-module, type_decoder, mapping instr[6:0] to the flag vector; instantiate it once on the accept path.

Verification
REQ-030 SHALL cover: 0x00500093 accepted, out_ready_i=1 -> next cycle out_valid_o=1, itype_o=1, other flags 0.
REQ-031 SHALL cover: 0x002081B3 then 0x0000A103 back-to-back, out_ready_i=0 -> rtype_o held, in_ready_o=0 after second accept; out_ready_i=1 -> load_o next.
REQ-032 SHALL cover: sequence 0x0020A023, 0x00208463, 0x008000EF, 0x000080E7, 0x123450B7 streaming -> store, branch, jal, jalr, lui one per cycle, no bubbles.
REQ-033 SHALL cover: flush_i with both entries full and in_valid_i=1 -> out_valid_o=0 and in_ready_o=1 next cycle, nothing accepted.
REQ-034 SHALL cover, with TYPE_DECODE_ILLEGAL_EN: 0x00000017 (auipc) consumed 256 times -> illegal_o=1, all flags 0, illegal_cnt_o ends at 255.
REQ-035 SHALL cover: rst_ni low for one edge with SKID full -> all outputs 0, in_ready_o=1 next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared opcode constants and decoded-entry types for the decode stage.
package core_pkg;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef struct packed {
        logic rtype;
        logic itype;
        logic store;
        logic load;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
    } flags_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        flags_t      flags;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/type_decode_stage_if.sv
// Upstream/downstream handshake bundle for type_decode_stage.
interface type_decode_stage_if;

    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        rtype_o;
    logic        itype_o;
    logic        store_o;
    logic        load_o;
    logic        branch_o;
    logic        jal_o;
    logic        jalr_o;
    logic        lui_o;
    logic        illegal_o;
    logic [7:0]  illegal_cnt_o;

    modport slave (
        input  in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, pc_o, rtype_o, itype_o, store_o, load_o,
               branch_o, jal_o, jalr_o, lui_o, illegal_o, illegal_cnt_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, pc_o, rtype_o, itype_o, store_o, load_o,
               branch_o, jal_o, jalr_o, lui_o, illegal_o, illegal_cnt_o
    );

endinterface

// File: rtl/type_decoder.sv
// Combinational opcode -> one-hot type flag decoder.
module type_decoder
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output flags_t     flags
);

    always_comb begin
        flags = '0;
        unique case (opcode)
            OpR:      flags.rtype  = 1'b1;
            OpI:      flags.itype  = 1'b1;
            OpLoad:   flags.load   = 1'b1;
            OpStore:  flags.store  = 1'b1;
            OpBranch: flags.branch = 1'b1;
            OpJal:    flags.jal    = 1'b1;
            OpJalr:   flags.jalr   = 1'b1;
            OpLui:    flags.lui    = 1'b1;
            default:  flags        = '0;
        endcase
    end

endmodule

// File: rtl/type_decode_stage.sv
// Decode stage: 2-entry skid buffer carrying instructions with pre-decoded type flags.
// Optional illegal-opcode flagging and counting enabled by TYPE_DECODE_ILLEGAL_EN.
module type_decode_stage
    import core_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    type_decode_stage_if.slave  bus
);

    entry_t out_q, out_d, skid_q, skid_d, in_entry;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   accept, consume;
    flags_t dec_flags;

    type_decoder u_type_decoder (
        .opcode (bus.instr_i[6:0]),
        .flags  (dec_flags)
    );

    // in_ready depends only on registered state, never on out_ready.
    assign accept  = bus.in_valid_i && !skid_valid_q;
    assign consume = out_valid_q && bus.out_ready_i;

    always_comb begin
        in_entry       = '0;
        in_entry.instr = bus.instr_i;
        in_entry.pc    = bus.pc_i;
        in_entry.flags = dec_flags;
`ifdef TYPE_DECODE_ILLEGAL_EN
        in_entry.illegal = ~|dec_flags || (bus.instr_i[1:0] != 2'b11);
`endif
    end

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume && skid_valid_q) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
        end else if (out_valid_q && !consume) begin
            if (accept) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end else begin
            out_valid_d = accept;
            if (accept) begin
                out_d = in_entry;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready_o  = !skid_valid_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.instr_o     = out_q.instr;
    assign bus.pc_o        = out_q.pc;
    assign bus.rtype_o     = out_valid_q & out_q.flags.rtype;
    assign bus.itype_o     = out_valid_q & out_q.flags.itype;
    assign bus.store_o     = out_valid_q & out_q.flags.store;
    assign bus.load_o      = out_valid_q & out_q.flags.load;
    assign bus.branch_o    = out_valid_q & out_q.flags.branch;
    assign bus.jal_o       = out_valid_q & out_q.flags.jal;
    assign bus.jalr_o      = out_valid_q & out_q.flags.jalr;
    assign bus.lui_o       = out_valid_q & out_q.flags.lui;

`ifdef TYPE_DECODE_ILLEGAL_EN
    logic [7:0] illegal_cnt_q;

    // Counts consumed illegal entries; a flush suppresses the consume.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            illegal_cnt_q <= '0;
        end else if (!flush_i && consume && out_q.illegal && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_q <= illegal_cnt_q + 8'd1;
        end
    end

    assign bus.illegal_o     = out_valid_q & out_q.illegal;
    assign bus.illegal_cnt_o = illegal_cnt_q;
`else
    assign bus.illegal_o     = 1'b0;
    assign bus.illegal_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_type_decode_stage.sv
// Directed self-checking bench for type_decode_stage (illegal checks follow TYPE_DECODE_ILLEGAL_EN).
module tb_type_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   vectors = 0;
    int   fails   = 0;
    logic [7:0] flags;

    type_decode_stage_if bus ();

    type_decode_stage dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign flags = {bus.rtype_o, bus.itype_o, bus.store_o, bus.load_o,
                    bus.branch_o, bus.jal_o, bus.jalr_o, bus.lui_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid_i = v;
        bus.instr_i    = ins;
        bus.pc_i       = pc;
    endtask

    logic [31:0] seq_ins [5];
    logic [7:0]  seq_flg [5];

    initial begin
        seq_ins = '{32'h0020A023, 32'h00208463, 32'h008000EF, 32'h000080E7, 32'h123450B7};
        seq_flg = '{8'h20, 8'h08, 8'h04, 8'h02, 8'h01};

        // Reset
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        chk("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        chk("rst_flags", {24'd0, flags}, 32'd0);
        chk("rst_instr", bus.instr_o, 32'd0);
        chk("rst_pc", bus.pc_o, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal_o}, 32'd0);
        chk("rst_cnt", {24'd0, bus.illegal_cnt_o}, 32'd0);
        rst_n = 1'b1;

        // Single I-type, one-cycle latency
        bus.out_ready_i = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("itype_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("itype_flags", {24'd0, flags}, 32'h40);
        chk("itype_instr", bus.instr_o, 32'h00500093);
        chk("itype_pc", bus.pc_o, 32'h100);
        step();
        chk("itype_drained", {31'd0, bus.out_valid_o}, 32'd0);
        chk("idle_flags", {24'd0, flags}, 32'd0);

        // Back-to-back with downstream stalled
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h200);
        step();
        chk("r_flags", {24'd0, flags}, 32'h80);
        chk("r_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        drive(1'b1, 32'h0000A103, 32'h204);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("skid_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
        chk("r_held_flags", {24'd0, flags}, 32'h80);
        chk("r_held_instr", bus.instr_o, 32'h002081B3);
        step();
        chk("r_stall_instr", bus.instr_o, 32'h002081B3);
        chk("r_stall_pc", bus.pc_o, 32'h200);
        bus.out_ready_i = 1'b1;
        step();
        chk("load_flags", {24'd0, flags}, 32'h10);
        chk("load_instr", bus.instr_o, 32'h0000A103);
        chk("load_pc", bus.pc_o, 32'h204);
        chk("load_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        step();
        chk("load_drained", {31'd0, bus.out_valid_o}, 32'd0);

        // Streaming, no bubbles
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq_ins[i], 32'h300 + 32'(i * 4));
            step();
            chk("stream_valid", {31'd0, bus.out_valid_o}, 32'd1);
            chk("stream_flags", {24'd0, flags}, {24'd0, seq_flg[i]});
            chk("stream_instr", bus.instr_o, seq_ins[i]);
            chk("stream_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("stream_drained", {31'd0, bus.out_valid_o}, 32'd0);

        // Flush with both entries full and a pending input
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'h00500093, 32'h400);
        step();
        drive(1'b1, 32'h002081B3, 32'h404);
        step();
        chk("full_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h0000A103, 32'h408);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        chk("flush_flags", {24'd0, flags}, 32'd0);
        step();
        chk("flush_nothing_acc", {31'd0, bus.out_valid_o}, 32'd0);

        // Flush beats an accept that would land in SKID
        drive(1'b1, 32'h00500093, 32'h500);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h504);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush2_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("flush2_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        step();
        chk("flush2_empty", {31'd0, bus.out_valid_o}, 32'd0);

        // Unknown opcode (auipc)
        bus.out_ready_i = 1'b1;
`ifdef TYPE_DECODE_ILLEGAL_EN
        drive(1'b1, 32'h00000017, 32'h600);
        for (int i = 0; i < 256; i++) begin
            step();
            chk("auipc_valid", {31'd0, bus.out_valid_o}, 32'd1);
            chk("auipc_illegal", {31'd0, bus.illegal_o}, 32'd1);
            chk("auipc_flags", {24'd0, flags}, 32'd0);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("cnt_saturated", {24'd0, bus.illegal_cnt_o}, 32'd255);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("cnt_after_flush", {24'd0, bus.illegal_cnt_o}, 32'd255);
`else
        drive(1'b1, 32'h00000017, 32'h600);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("auipc_valid", {31'd0, bus.out_valid_o}, 32'd1);
        chk("auipc_flags", {24'd0, flags}, 32'd0);
        chk("auipc_illegal", {31'd0, bus.illegal_o}, 32'd0);
        step();
        chk("auipc_cnt", {24'd0, bus.illegal_cnt_o}, 32'd0);
`endif

        // Reset mid-operation with SKID full
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'h00500093, 32'h700);
        step();
        drive(1'b1, 32'h123450B7, 32'h704);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("pre_rst_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        chk("mid_rst_flags", {24'd0, flags}, 32'd0);
        chk("mid_rst_instr", bus.instr_o, 32'd0);
        chk("mid_rst_pc", bus.pc_o, 32'd0);
        chk("mid_rst_cnt", {24'd0, bus.illegal_cnt_o}, 32'd0);
        bus.out_ready_i = 1'b1;
        step();
        chk("post_rst_empty", {31'd0, bus.out_valid_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
